chad_io_resp: RTL and testbench
===============================

Name: chad_io_resp

Overview:
I/O-space responder for the chad core, sitting on the core's io_rd/io_wr strobes and decoding the low bits of the T-derived address. It provides a UART transmitter with a small FIFO, a GPIO output register and a free-running cycle counter. It stretches core accesses with hold when it needs time: registered read data, or a write to a full TX FIFO.

Parameters:
WIDTH, 18, cell width; matches the core, 16..32.
BAUD_DIV, 434, clocks per UART bit; must be >= 2.
FIFO_LOG2, 2, log2 of TX FIFO depth (default depth 4).
GPIO_BITS, 8, width of GPIO output register; must be <= WIDTH.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous active-high reset.
io_rd  in  1  core I/O read strobe.
io_wr  in  1  core I/O write strobe.
io_addr  in  4  I/O register select; core mem_addr[3:0].
din  in  WIDTH  write data; core dout (N).
dout  out  WIDTH  read data; drives core io_din.
hold  out  1  wait-state request to the core; combinational.
txd  out  1  UART serial output, idle high.
gpio  out  GPIO_BITS  GPIO output register.

Behaviour:
- Reset values: dout=0, hold=0, txd=1, gpio=0. FIFO empty, shifter idle, served=0, counter=0.
- Reset asserted mid-frame aborts the frame: txd=1 on the next cycle and FIFO contents are discarded.
- Register map (io_addr):
  - 0: write pushes din[7:0] to the TX FIFO. Read returns status: bit0 FIFO full, bit1 FIFO empty, bit2 shifter busy; other bits 0.
  - 1: GPIO, read/write. Read returns gpio zero-extended.
  - 2: cycle counter; see Optional Feature.
  - 3..15: read 0; writes ignored.
- Read handshake (two cycles, one wait state):
  - Cycle A, io_rd=1 and served=0: hold=1; the selected value is latched into dout; served<=1.
  - Cycle B, io_rd=1 and served=1 (the core holds its instruction, so io_rd persists): hold=0; dout is stable for the core; served<=0.
  - dout keeps its last value between reads.
  - io_rd dropping while served=1 clears served.
- Write handshake:
  - GPIO and counter writes complete in the io_wr cycle with hold=0.
  - Write to addr 0 with FIFO not full: push, hold=0.
  - Write to addr 0 with FIFO full: hold=1 and no push, repeated every cycle until a pop frees a slot.
  - Hold is computed from the current full flag. A pop in the same cycle therefore still stalls; the push happens the next cycle.
- io_rd and io_wr together: the read is serviced and the write is ignored. This is a core fault case.
- FIFO: circular buffer, FIFO_LOG2-bit read/write pointers plus a count. Push and pop in the same cycle leave the count unchanged.
- TX state machine: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - START: txd=0 for BAUD_DIV clocks.
  - DATA: 8 bits, LSB first, BAUD_DIV clocks each.
  - STOP: txd=1 for BAUD_DIV clocks, then IDLE.
  - A frame lasts exactly 10*BAUD_DIV clocks. Back-to-back frames have no idle gap: the pop occurs on the final STOP clock.
  - Busy = state != IDLE.
- The baud counter reloads at each bit boundary.

Optional Feature:
Macro IO_CYCLE_COUNTER_EN.
- Defined: addr 2 is a WIDTH-bit counter incrementing every clock, including during hold, and wrapping from all-ones to 0. Read returns the value latched in cycle A. A write loads din; that clock's increment is replaced by the load.
- Undefined: no counter logic; addr 2 reads 0 and writes are ignored.

Test Plan:
- Reset, then io_wr to addr 1 with din=0x0A5 -> gpio=0xA5 next cycle, hold=0. Read addr 1 -> hold=1 for one cycle, then dout=0x0A5 with hold=0.
- BAUD_DIV=4, write 0x55 to addr 0 -> txd low 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, high 4 clocks. 40 clocks total; status bit2=0 afterwards.
- BAUD_DIV=4, FIFO_LOG2=2, five back-to-back writes to addr 0:
  - first is popped immediately;
  - 2nd-5th fill the FIFO (full);
  - a 6th write asserts hold until the first frame's final STOP clock, then pushes the cycle after;
  - no byte is lost or duplicated across the six frames.
- Reset asserted during DATA bit 3 -> txd=1 next cycle; status reads empty=1, busy=0, full=0.
- With IO_CYCLE_COUNTER_EN, write 0x3FFFE to addr 2 (WIDTH=18), read two cycles later -> wrap observed, value 0x00000 or 0x00001 per latch timing. Without the macro, reading addr 2 -> 0.
- Read addr 7 -> dout=0 after one wait state. io_rd and io_wr together on addr 1 -> gpio unchanged.

Source files
------------

// File: rtl/chad_io_resp.sv
// chad_io_resp: chad I/O responder (UART TX FIFO, GPIO, cycle counter under IO_CYCLE_COUNTER_EN)
module chad_io_resp #(
   parameter int WIDTH     = 18,
   parameter int BAUD_DIV  = 434,
   parameter int FIFO_LOG2 = 2,
   parameter int GPIO_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_rd,
   input  logic                 io_wr,
   input  logic [3:0]           io_addr,
   input  logic [WIDTH-1:0]     din,
   output logic [WIDTH-1:0]     dout,
   output logic                 hold,
   output logic                 txd,
   output logic [GPIO_BITS-1:0] gpio
);
   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int CW = FIFO_LOG2 + 1;
   localparam int BW = $clog2(BAUD_DIV);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   tx_state_t state, state_n;
   logic [7:0] mem [DEPTH];
   logic [FIFO_LOG2-1:0] wp, rp;
   logic [CW-1:0] count;
   logic [BW-1:0] baud;
   logic [2:0] bit_idx;
   logic [7:0] sh;
   logic served, full, empty, busy, push, pop, wr_ok, bit_end;
   logic [WIDTH-1:0] status, cyc_val, rd_val;
   logic unused_din;
   assign unused_din = ^din;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign busy = state != IDLE;
   assign wr_ok = io_wr && !io_rd;
   assign push = wr_ok && io_addr == 4'd0 && !full;
   assign hold = io_rd ? !served : (io_wr && io_addr == 4'd0 && full);
   assign bit_end = baud == '0;
   assign txd = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
   assign status = {{(WIDTH-3){1'b0}}, busy, empty, full};
`ifdef IO_CYCLE_COUNTER_EN
   logic [WIDTH-1:0] cyc;
   assign cyc_val = cyc;
   always_ff @(posedge clk)
      if (reset) cyc <= '0;
      else cyc <= (wr_ok && io_addr == 4'd2) ? din : cyc + WIDTH'(1);
`else
   assign cyc_val = '0;
`endif
   assign rd_val = io_addr == 4'd0 ? status :
                   io_addr == 4'd1 ? WIDTH'(gpio) :
                   io_addr == 4'd2 ? cyc_val : '0;
   always_ff @(posedge clk)
      if (reset) begin
         served <= 1'b0;
         dout <= '0;
         gpio <= '0;
      end else begin
         served <= io_rd && !served;
         if (io_rd && !served) dout <= rd_val;
         if (wr_ok && io_addr == 4'd1) gpio <= din[GPIO_BITS-1:0];
      end
   always_ff @(posedge clk)
      if (push) mem[wp] <= din[7:0];
   always_ff @(posedge clk)
      if (reset) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + FIFO_LOG2'(1);
         if (pop) rp <= rp + FIFO_LOG2'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   // A frame ending with data queued pops on its last STOP clock, so frames abut.
   always_comb begin
      state_n = state;
      pop = 1'b0;
      case (state)
         IDLE: begin
            pop = !empty;
            state_n = empty ? IDLE : START;
         end
         START: state_n = bit_end ? DATA : START;
         DATA: state_n = (bit_end && bit_idx == 3'd7) ? STOP : DATA;
         STOP: begin
            pop = bit_end && !empty;
            state_n = !bit_end ? STOP : empty ? IDLE : START;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         baud <= '0;
         bit_idx <= '0;
         sh <= '0;
      end else begin
         state <= state_n;
         baud <= (pop || bit_end) ? BW'(BAUD_DIV - 1) : baud - BW'(1);
         bit_idx <= state == DATA ? bit_idx + 3'(bit_end) : 3'd0;
         if (pop) sh <= mem[rp];
         else if (state == DATA && bit_end) sh <= sh >> 1;
      end
endmodule

// File: tb/tb_chad_io_resp.sv
// tb_chad_io_resp: scoreboard bench for chad_io_resp; UART frames checked against queued bytes
module tb_chad_io_resp;
   localparam int W = 18;
   localparam int BD = 4;
   logic clk = 0, reset = 1, io_rd = 0, io_wr = 0, hold, txd;
   logic [3:0] io_addr = '0;
   logic [W-1:0] din = '0, dout;
   logic [7:0] gpio;
   int total = 0, bad = 0, frames = 0, cap_i = 0, st, st_sum, f0;
   logic [39:0] frame;
   logic [7:0] exp_q [$];
   logic [W-1:0] v;
   chad_io_resp #(.WIDTH(W), .BAUD_DIV(BD), .FIFO_LOG2(2), .GPIO_BITS(8)) dut (
      .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
      .din(din), .dout(dout), .hold(hold), .txd(txd), .gpio(gpio));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   function automatic logic [39:0] mk_frame(input logic [7:0] b);
      logic [39:0] f;
      for (int i = 0; i < 40; i++) f[i] = i < BD ? 1'b0 : i >= 9*BD ? 1'b1 : b[(i-BD)/BD];
      return f;
   endfunction
   // Receiver: one txd sample per clock, 40 samples per frame from the start bit.
   initial forever begin
      @(negedge clk);
      if (reset) cap_i = 0;
      else if (cap_i == 0 && txd !== 1'b0) ;
      else begin
         frame[cap_i] = txd;
         cap_i++;
         if (cap_i == 40) begin
            cap_i = 0;
            frames++;
            if (exp_q.size() == 0) chk("unexpected_frame", frame, '1);
            else chk("uart_frame", frame, mk_frame(exp_q.pop_front()));
         end
      end
   end
   task automatic wr(input logic [3:0] a, input logic [W-1:0] d, output int stalls);
      io_wr = 1; io_addr = a; din = d; stalls = 0;
      if (a == 4'd0) exp_q.push_back(d[7:0]);
      #1;
      while (hold && stalls < 200) begin
         tick;
         stalls++;
      end
      if (stalls == 200) chk("wr_stall_timeout", 1, 0);
      tick;
      io_wr = 0;
   endtask
   task automatic rd(input logic [3:0] a, output logic [W-1:0] val);
      io_rd = 1; io_addr = a;
      #1;
      chk("rd_hold_a", hold, 1);
      tick;
      chk("rd_hold_b", hold, 0);
      val = dout;
      tick;
      io_rd = 0;
   endtask
   initial begin
      repeat (3) tick;
      chk("rst_dout", dout, 0);
      chk("rst_hold", hold, 0);
      chk("rst_txd", txd, 1);
      chk("rst_gpio", gpio, 0);
      reset = 0;
      io_wr = 1; io_addr = 4'd1; din = 18'h0A5;
      #1;
      chk("gpio_wr_hold", hold, 0);
      tick;
      io_wr = 0;
      chk("gpio_val", gpio, 8'hA5);
      rd(4'd1, v);
      chk("gpio_rd", v, 18'h0A5);
      rd(4'd7, v);
      chk("rd_addr7", v, 0);
      io_wr = 1; din = 18'h03C;
      rd(4'd1, v);
      io_wr = 0;
      chk("rdwr_gpio", gpio, 8'hA5);
      chk("rdwr_dout", v, 18'h0A5);
      wr(4'd2, 18'h3FFFE, st);
      tick;
      rd(4'd2, v);
`ifdef IO_CYCLE_COUNTER_EN
      chk("cnt_pre", v, 18'h3FFFF);
`else
      chk("cnt_pre", v, 0);
`endif
      rd(4'd2, v);
`ifdef IO_CYCLE_COUNTER_EN
      chk("cnt_wrap", v, 18'h00001);
`else
      chk("cnt_wrap", v, 0);
`endif
      f0 = frames;
      wr(4'd0, 18'h055, st);
      chk("tx55_stall", st, 0);
      tick; tick;
      rd(4'd0, v);
      chk("status_busy", v, 18'h6);
      repeat (45) tick;
      chk("tx55_frames", frames - f0, 1);
      rd(4'd0, v);
      chk("status_idle", v, 18'h2);
      f0 = frames;
      st_sum = 0;
      foreach (gpio[i]) ;
      wr(4'd0, 18'h011, st); st_sum += st;
      wr(4'd0, 18'h022, st); st_sum += st;
      wr(4'd0, 18'h083, st); st_sum += st;
      wr(4'd0, 18'h0C4, st); st_sum += st;
      wr(4'd0, 18'h035, st); st_sum += st;
      chk("fill_stalls", st_sum, 0);
      rd(4'd0, v);
      chk("status_full", v, 18'h5);
      wr(4'd0, 18'h0F6, st);
      chk("full_stall", st, 35);
      repeat (250) tick;
      chk("b2b_frames", frames - f0, 6);
      chk("queue_empty", exp_q.size(), 0);
      wr(4'd0, 18'h0A3, st);
      wr(4'd0, 18'h05A, st);
      wr(4'd0, 18'h00F, st);
      repeat (17) tick;
      chk("pre_rst_txd", txd, 0);
      reset = 1;
      tick;
      chk("rst_mid_txd", txd, 1);
      reset = 0;
      exp_q.delete();
      f0 = frames;
      rd(4'd0, v);
      chk("rst_status", v, 18'h2);
      repeat (60) tick;
      chk("rst_no_frames", frames - f0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
